// File: rtl/mem_pkg.sv
// +--------------------------------------------------------------------+
// | mem_pkg : shared encodings for the data-memory access path. Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  localparam int DEF_ADDR_WORDS = 64;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4,
    ST_ERR      = 3'd5
  } state_e;

  function automatic logic misaligned(input size_e size, input logic [1:0] lane);
    case (size)
      SZ_HALF: misaligned = lane[0];
      SZ_WORD: misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// +--------------------------------------------------------------------+
// | mem_lane_align : byte-lane extract/extend and merge. Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_mask;

  assign w_shamt   = {lane, 3'b000};
  assign w_shifted = word >> w_shamt;

  always_comb begin
    load_data   = w_shifted;
    merged_word = word;
    w_mask      = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{is_signed & w_shifted[7]}}, w_shifted[7:0]};
        w_mask    = 32'h0000_00FF << w_shamt;
        merged_word = (word & ~w_mask) | (({24'b0, wdata[7:0]} << w_shamt) & w_mask);
      end
      SZ_HALF: begin
        load_data = {{16{is_signed & w_shifted[15]}}, w_shifted[15:0]};
        w_mask    = 32'h0000_FFFF << w_shamt;
        merged_word = (word & ~w_mask) | (({16'b0, wdata[15:0]} << w_shamt) & w_mask);
      end
      default: begin
        load_data   = word;
        merged_word = wdata;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +--------------------------------------------------------------------+
// | mem_access_unit : load/store initiator for word memory. Rev 1.0     |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WORDS = DEF_ADDR_WORDS,
  parameter int IDX_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         lane_q, lane_d;
  size_e              size_q, size_d;
  logic               signed_q, signed_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               mem_write_q, mem_write_d;
  logic               mem_read_q, mem_read_d;

  logic               w_req_err;
  logic [31:0]        w_load_data;
  logic [31:0]        w_merged;

  assign w_req_err = (size_e'(req_size) == SZ_ILL)
                   || misaligned(size_e'(req_size), req_addr[1:0])
                   || ({2'b00, req_addr[31:2]} >= 32'(ADDR_WORDS));

  mem_lane_align u_align (
    .word        (mem_read_data),
    .lane        (lane_q),
    .size        (size_q),
    .is_signed   (signed_q),
    .wdata       (wdata_q),
    .load_data   (w_load_data),
    .merged_word (w_merged)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    size_d   = size_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          idx_d    = req_addr[IDX_W+1:2];
          lane_d   = req_addr[1:0];
          size_d   = size_e'(req_size);
          signed_d = req_signed;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          if (w_req_err)                           state_d = ST_ERR;
          else if (!req_write)                     state_d = ST_READ;
          else if (size_e'(req_size) == SZ_WORD)   state_d = ST_WRITE;
          else                                     state_d = ST_RMW_READ;
        end
      end
      ST_READ: begin
        rdata_d = w_load_data;
        state_d = ST_RESP;
      end
      ST_RMW_READ: begin
        wdata_d = w_merged;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered: decode them from the state being entered.
    req_ready_d  = (state_d == ST_IDLE);
    mem_read_d   = (state_d == ST_READ) || (state_d == ST_RMW_READ);
    mem_write_d  = (state_d == ST_WRITE);
    mem_addr_d   = (mem_read_d || mem_write_d) ? {{(32-IDX_W){1'b0}}, idx_d} : 32'h0;
    mem_wdata_d  = mem_write_d ? wdata_d : 32'h0;
    resp_valid_d = (state_d == ST_RESP) || (state_d == ST_ERR);
    resp_err_d   = (state_d == ST_ERR);
    resp_rdata_d = (state_d == ST_RESP) ? rdata_d : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      lane_q       <= 2'b00;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_write      = mem_write_q;
  assign mem_read       = mem_read_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +--------------------------------------------------------------------+
// | tb_mem_access_unit : bench with word memory and reference model.    |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Attached word memory: combinational read, write on rising edge.
  logic [31:0] mem [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = 6'd0;
  logic [31:0] bd_data = 32'h0;

  assign mem_read_data = mem_read ? mem[mem_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (bd_we)     mem[bd_idx] <= bd_data;
    if (mem_write) mem[mem_addr[5:0]] <= mem_write_data;
  end

  logic [31:0] ref_mem [64];
  int total = 0;
  int bad   = 0;

  logic [31:0] got_rd, got_raddr, got_waddr, got_wdata;
  logic        got_err, got_ok;
  int          got_lat, got_nrd, got_nwr, got_both;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: result, memory effect, latency and access counts from the access rules.
  task automatic ref_model(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic e, output int lat,
                           output int nrd, output int nwr, output logic [31:0] wword);
    int idx, sh, nbytes;
    logic [31:0] word, mask, v;
    e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a / 4 >= 64);
    rd = 32'h0; wword = 32'h0; lat = 1; nrd = 0; nwr = 0;
    if (e) return;
    idx    = int'(a / 4);
    sh     = 8 * int'(a % 4);
    word   = ref_mem[idx];
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    if (!w) begin
      v = (word >> sh) & mask;
      if (sg && nbytes < 4 && v > (mask >> 1)) v = v - (mask + 32'd1);
      rd = v; lat = 2; nrd = 1;
    end else begin
      ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
      wword = ref_mem[idx];
      nwr = 1;
      nrd = (nbytes == 4) ? 0 : 1;
      lat = (nbytes == 4) ? 2 : 3;
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    int g = 0;
    @(negedge clk);
    while (!req_ready && g < 10) begin @(negedge clk); g++; end
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got_ok = 1'b0; got_lat = 0; got_nrd = 0; got_nwr = 0; got_both = 0;
    got_rd = 32'h0; got_err = 1'b0; got_raddr = 32'h0; got_waddr = 32'h0; got_wdata = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read)  begin got_nrd++; got_raddr = mem_addr; end
      if (mem_write) begin got_nwr++; got_waddr = mem_addr; got_wdata = mem_write_data; end
      if (mem_read && mem_write) got_both++;
      if (resp_valid) begin
        got_lat = c; got_rd = resp_rdata; got_err = resp_err; got_ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic compare(input string tag, input logic [31:0] e_rd, input logic e_err,
                         input int e_lat, input int e_nrd, input int e_nwr,
                         input logic [31:0] e_maddr, input logic [31:0] e_wword);
    check({tag, ".done"},  32'(got_ok), 32'd1);
    check({tag, ".err"},   32'(got_err), 32'(e_err));
    check({tag, ".rdata"}, got_rd, e_rd);
    check({tag, ".lat"},   32'(got_lat), 32'(e_lat));
    check({tag, ".nrd"},   32'(got_nrd), 32'(e_nrd));
    check({tag, ".nwr"},   32'(got_nwr), 32'(e_nwr));
    check({tag, ".both"},  32'(got_both), 32'd0);
    if (e_nrd > 0) check({tag, ".raddr"}, got_raddr, e_maddr);
    if (e_nwr > 0) begin
      check({tag, ".waddr"}, got_waddr, e_maddr);
      check({tag, ".wdata"}, got_wdata, e_wword);
    end
  endtask

  task automatic run_random(input string tag, input logic w, input logic [1:0] sz,
                            input logic sg, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] e_rd, e_ww;
    logic e_err;
    int e_lat, e_nrd, e_nwr;
    ref_model(w, sz, sg, a, wd, e_rd, e_err, e_lat, e_nrd, e_nwr, e_ww);
    issue(w, sz, sg, a, wd);
    compare(tag, e_rd, e_err, e_lat, e_nrd, e_nwr, a >> 2, e_ww);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] maddr;
    logic [31:0] wword;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d_rd, d_ww, a, wd;
    logic d_err;
    int d_lat, d_nrd, d_nwr, diffs, seen;

    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h0C,  32'h0,        32'h8844_2211, 1'b0, 2, 1, 0, 32'd3, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0F,  32'h0,        32'hFFFF_FF88, 1'b0, 2, 1, 0, 32'd3, 32'h0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0F,  32'h0,        32'h0000_0088, 1'b0, 2, 1, 0, 32'd3, 32'h0};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h0E,  32'h0,        32'hFFFF_8844, 1'b0, 2, 1, 0, 32'd3, 32'h0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h0C,  32'h0,        32'h0000_2211, 1'b0, 2, 1, 0, 32'd3, 32'h0};
    vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h0D,  32'h0000_00AB, 32'h0,        1'b0, 3, 1, 1, 32'd3, 32'h8844_AB11};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h0C,  32'h0,        32'h8844_AB11, 1'b0, 2, 1, 0, 32'd3, 32'h0};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEAD_BEEF, 32'h0,        1'b0, 2, 0, 1, 32'd4, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEAD_BEEF, 1'b0, 2, 1, 0, 32'd4, 32'h0};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h01,  32'h0,        32'h0,         1'b1, 1, 0, 0, 32'd0, 32'h0};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h0,         1'b1, 1, 0, 0, 32'd0, 32'h0};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h0,   32'h0,        32'h0,         1'b1, 1, 0, 0, 32'd0, 32'h0};

    // Fill memory (and the model's copy) while reset is held.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_idx = 6'(i);
      bd_data = (i == 3) ? 32'h8844_2211 : $urandom;
      ref_mem[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;

    check("rst.req_ready",  32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_err",   32'(resp_err), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'h0);
    check("rst.mem_read",   32'(mem_read), 32'd0);
    check("rst.mem_write",  32'(mem_write), 32'd0);
    check("rst.mem_addr",   mem_addr, 32'h0);
    check("rst.mem_wdata",  mem_write_data, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      ref_model(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd,
                d_rd, d_err, d_lat, d_nrd, d_nwr, d_ww);
      issue(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd);
      compare($sformatf("vec%0d", i), vecs[i].rd, vecs[i].err, vecs[i].lat,
              vecs[i].nrd, vecs[i].nwr, vecs[i].maddr, vecs[i].wword);
    end

    // Reset during the write cycle of a byte store to word 2.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h09; req_wdata = 32'h0000_0055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 6 && seen == 0; c++) begin
      @(negedge clk);
      if (mem_write) seen = 1;
    end
    check("rstmid.write_seen", 32'(seen), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rstmid.mem_write",  32'(mem_write), 32'd0);
    check("rstmid.mem_read",   32'(mem_read), 32'd0);
    check("rstmid.resp_valid", 32'(resp_valid), 32'd0);
    check("rstmid.mem_addr",   mem_addr, 32'h0);
    check("rstmid.req_ready",  32'(req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid || mem_write) seen++;
    end
    check("rstmid.quiet", 32'(seen), 32'd0);
    check("rstmid.word2", mem[2], ref_mem[2]);
    check("rstmid.ready", 32'(req_ready), 32'd1);
    run_random("rstmid.load", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);

    // Randomized requests against the model.
    for (int n = 0; n < 60; n++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 9) == 0) a = $urandom;
      wd = $urandom;
      run_random($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), sz,
                 1'($urandom_range(0, 1)), a, wd);
    end

    @(negedge clk);
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image_diffs", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
